// File: rtl/cc_max_finder_pkg.sv
// Shared definitions for the running-maximum search block.
// Holds the state encoding and the index-width helper.
package cc_max_finder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Smallest width able to count 0..words-1, i.e. ceil(log2(words)).
    function automatic int index_width(input int words);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < words) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/cc_max_finder_greaterthan.sv
// Unsigned full-width strict magnitude comparator: greaterthan_Out = (A > B).
// Equal operands report 0, which is what makes the search keep the earliest index.
module CC_GREATERTHAN
    import cc_max_finder_pkg::*;
#(
    parameter int NUMBER_DATAWIDTH = 8
) (
    input  logic [NUMBER_DATAWIDTH-1:0] CC_GREATERTHAN_dataA_InBUS,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_GREATERTHAN_dataB_InBUS,
    output logic                        CC_GREATERTHAN_greaterthan_Out
);

    assign CC_GREATERTHAN_greaterthan_Out =
        (CC_GREATERTHAN_dataA_InBUS > CC_GREATERTHAN_dataB_InBUS);

endmodule

// File: rtl/cc_max_finder.sv
// Running-maximum search over a burst of NUMBER_WORDS words taken on a valid/ready stream.
// Reports the maximum and the index of its first occurrence, then pulses done for one cycle.
module cc_max_finder
    import cc_max_finder_pkg::*;
#(
    parameter int NUMBER_DATAWIDTH  = 8,
    parameter int NUMBER_WORDS      = 16,
    parameter int NUMBER_INDEXWIDTH = 4
) (
    input  logic                         CC_MAXFINDER_CLOCK_50,
    input  logic                         CC_MAXFINDER_RESET_InLow,
    input  logic                         CC_MAXFINDER_start_In,
    input  logic                         CC_MAXFINDER_clear_In,
    input  logic [NUMBER_DATAWIDTH-1:0]  CC_MAXFINDER_data_InBUS,
    input  logic                         CC_MAXFINDER_dataValid_In,
    output logic                         CC_MAXFINDER_dataReady_Out,
    output logic [NUMBER_DATAWIDTH-1:0]  CC_MAXFINDER_max_OutBUS,
    output logic [NUMBER_INDEXWIDTH-1:0] CC_MAXFINDER_index_OutBUS,
    output logic                         CC_MAXFINDER_busy_Out,
    output logic                         CC_MAXFINDER_done_Out
);

    localparam int LP_CW = index_width(NUMBER_WORDS);
    localparam logic [LP_CW-1:0] LP_LAST = LP_CW'(NUMBER_WORDS - 1);
    localparam logic [LP_CW-1:0] LP_ONE  = LP_CW'(1);

    state_t                        r_state;
    logic [NUMBER_DATAWIDTH-1:0]   r_max;
    logic [NUMBER_INDEXWIDTH-1:0]  r_index;
    logic [LP_CW-1:0]              r_counter;
    logic                          r_ready;
    logic                          r_busy;
    logic                          r_done;

    logic                          w_transfer;
    logic                          w_greater;

    assign w_transfer = CC_MAXFINDER_dataValid_In & r_ready;

    CC_GREATERTHAN #(
        .NUMBER_DATAWIDTH(NUMBER_DATAWIDTH)
    ) u_greaterthan (
        .CC_GREATERTHAN_dataA_InBUS    (CC_MAXFINDER_data_InBUS),
        .CC_GREATERTHAN_dataB_InBUS    (r_max),
        .CC_GREATERTHAN_greaterthan_Out(w_greater)
    );

    // clear wins over everything else; ready/busy/done are registered alongside the state.
    always_ff @(posedge CC_MAXFINDER_CLOCK_50 or negedge CC_MAXFINDER_RESET_InLow) begin
        if (!CC_MAXFINDER_RESET_InLow) begin
            r_state   <= ST_IDLE;
            r_max     <= '0;
            r_index   <= '0;
            r_counter <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (CC_MAXFINDER_clear_In) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (CC_MAXFINDER_start_In) begin
                        r_state   <= ST_FIRST;
                        r_counter <= '0;
                        r_busy    <= 1'b1;
                        r_ready   <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_FIRST: begin
                    if (w_transfer) begin
                        r_max     <= CC_MAXFINDER_data_InBUS;
                        r_index   <= '0;
                        r_counter <= LP_ONE;
                        r_state   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_transfer) begin
                        if (w_greater) begin
                            r_max   <= CC_MAXFINDER_data_InBUS;
                            r_index <= NUMBER_INDEXWIDTH'(r_counter);
                        end
                        r_counter <= r_counter + LP_ONE;
                        if (r_counter == LP_LAST) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign CC_MAXFINDER_dataReady_Out = r_ready;
    assign CC_MAXFINDER_max_OutBUS    = r_max;
    assign CC_MAXFINDER_index_OutBUS  = r_index;
    assign CC_MAXFINDER_busy_Out      = r_busy;
    assign CC_MAXFINDER_done_Out      = r_done;

endmodule
